// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: the `instructions` entry struct, RV32 opcode/funct
// constants and immediate-extraction helpers used by decode_comb and decode_stage.
package decode_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] F3_FENCE   = 3'b000;
    localparam logic [2:0] F3_FENCE_I = 3'b001;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] F5_LR      = 5'b00010;
    localparam logic [4:0] F5_SC      = 5'b00011;
    localparam logic [4:0] F5_AMOSWAP = 5'b00001;
    localparam logic [4:0] F5_AMOADD  = 5'b00000;
    localparam logic [4:0] F5_AMOXOR  = 5'b00100;
    localparam logic [4:0] F5_AMOAND  = 5'b01100;
    localparam logic [4:0] F5_AMOOR   = 5'b01000;
    localparam logic [4:0] F5_AMOMIN  = 5'b10000;
    localparam logic [4:0] F5_AMOMAX  = 5'b10100;
    localparam logic [4:0] F5_AMOMINU = 5'b11000;
    localparam logic [4:0] F5_AMOMAXU = 5'b11100;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        writes_to_reg;
        logic        is_load;
        logic        is_store;
        logic        is_conditional_jump;
        logic        illegal;
        logic        aq;
        logic        rl;
        logic lui, auipc, jal, jalr;
        logic beq, bne, blt, bge, bltu, bgeu;
        logic lb, lh, lw, lbu, lhu, sb, sh, sw;
        logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
        logic add, sub, sll, slt, sltu, xor_, srl, sra, or_, and_;
        logic fence, fence_i, ecall, ebreak;
        logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
        logic lr_w, sc_w, amoswap_w, amoadd_w, amoxor_w, amoand_w, amoor_w;
        logic amomin_w, amomax_w, amominu_w, amomaxu_w;
    } instructions;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{21{w[31]}}, w[30:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{21{w[31]}}, w[30:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32IM word-to-entry decoder; lr/sc/amo*.w are decoded
// only when DECODE_RV32A_EN is defined, otherwise they fall through as illegal.
module decode_comb
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output instructions dec_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    always_comb begin
        instructions d;
        logic t_r, t_i, t_s, t_b, t_u, t_j;
        logic legal;

        d   = '0;
        t_r = 1'b0;
        t_i = 1'b0;
        t_s = 1'b0;
        t_b = 1'b0;
        t_u = 1'b0;
        t_j = 1'b0;

        // a type flag is raised only when the encoding fully matches
        case (opc)
            OP_LUI:   begin d.lui = 1'b1;   t_u = 1'b1; end
            OP_AUIPC: begin d.auipc = 1'b1; t_u = 1'b1; end
            OP_JAL:   begin d.jal = 1'b1;   t_j = 1'b1; end
            OP_JALR: begin
                if (f3 == 3'b000) begin d.jalr = 1'b1; t_i = 1'b1; end
            end
            OP_BRANCH: begin
                t_b = 1'b1;
                case (f3)
                    F3_BEQ:  d.beq  = 1'b1;
                    F3_BNE:  d.bne  = 1'b1;
                    F3_BLT:  d.blt  = 1'b1;
                    F3_BGE:  d.bge  = 1'b1;
                    F3_BLTU: d.bltu = 1'b1;
                    F3_BGEU: d.bgeu = 1'b1;
                    default: t_b = 1'b0;
                endcase
                d.is_conditional_jump = t_b;
            end
            OP_LOAD: begin
                t_i = 1'b1;
                case (f3)
                    F3_B:    d.lb  = 1'b1;
                    F3_H:    d.lh  = 1'b1;
                    F3_W:    d.lw  = 1'b1;
                    F3_BU:   d.lbu = 1'b1;
                    F3_HU:   d.lhu = 1'b1;
                    default: t_i = 1'b0;
                endcase
                d.is_load = t_i;
            end
            OP_STORE: begin
                t_s = 1'b1;
                case (f3)
                    F3_B:    d.sb = 1'b1;
                    F3_H:    d.sh = 1'b1;
                    F3_W:    d.sw = 1'b1;
                    default: t_s = 1'b0;
                endcase
                d.is_store = t_s;
            end
            OP_IMM: begin
                t_i = 1'b1;
                case (f3)
                    F3_ADD:  d.addi  = 1'b1;
                    F3_SLT:  d.slti  = 1'b1;
                    F3_SLTU: d.sltiu = 1'b1;
                    F3_XOR:  d.xori  = 1'b1;
                    F3_OR:   d.ori   = 1'b1;
                    F3_AND:  d.andi  = 1'b1;
                    F3_SLL: begin
                        if (f7 == F7_BASE) d.slli = 1'b1;
                        else               t_i    = 1'b0;
                    end
                    default: begin
                        if      (f7 == F7_BASE) d.srli = 1'b1;
                        else if (f7 == F7_ALT)  d.srai = 1'b1;
                        else                    t_i    = 1'b0;
                    end
                endcase
            end
            OP_REG: begin
                t_r = 1'b1;
                case ({f7, f3})
                    {F7_BASE,   F3_ADD}:    d.add    = 1'b1;
                    {F7_ALT,    F3_ADD}:    d.sub    = 1'b1;
                    {F7_BASE,   F3_SLL}:    d.sll    = 1'b1;
                    {F7_BASE,   F3_SLT}:    d.slt    = 1'b1;
                    {F7_BASE,   F3_SLTU}:   d.sltu   = 1'b1;
                    {F7_BASE,   F3_XOR}:    d.xor_   = 1'b1;
                    {F7_BASE,   F3_SR}:     d.srl    = 1'b1;
                    {F7_ALT,    F3_SR}:     d.sra    = 1'b1;
                    {F7_BASE,   F3_OR}:     d.or_    = 1'b1;
                    {F7_BASE,   F3_AND}:    d.and_   = 1'b1;
                    {F7_MULDIV, F3_MUL}:    d.mul    = 1'b1;
                    {F7_MULDIV, F3_MULH}:   d.mulh   = 1'b1;
                    {F7_MULDIV, F3_MULHSU}: d.mulhsu = 1'b1;
                    {F7_MULDIV, F3_MULHU}:  d.mulhu  = 1'b1;
                    {F7_MULDIV, F3_DIV}:    d.div    = 1'b1;
                    {F7_MULDIV, F3_DIVU}:   d.divu   = 1'b1;
                    {F7_MULDIV, F3_REM}:    d.rem    = 1'b1;
                    {F7_MULDIV, F3_REMU}:   d.remu   = 1'b1;
                    default:                t_r      = 1'b0;
                endcase
            end
            OP_FENCE: begin
                t_i = 1'b1;
                case (f3)
                    F3_FENCE:   d.fence   = 1'b1;
                    F3_FENCE_I: d.fence_i = 1'b1;
                    default:    t_i       = 1'b0;
                endcase
            end
            OP_SYSTEM: begin
                if (instr_i == INSTR_ECALL)  begin d.ecall  = 1'b1; t_i = 1'b1; end
                if (instr_i == INSTR_EBREAK) begin d.ebreak = 1'b1; t_i = 1'b1; end
            end
`ifdef DECODE_RV32A_EN
            OP_AMO: begin
                if (f3 == F3_W) begin
                    t_r = 1'b1;
                    case (instr_i[31:27])
                        F5_LR: begin
                            if (instr_i[24:20] == 5'd0) d.lr_w = 1'b1;
                            else                        t_r    = 1'b0;
                        end
                        F5_SC:      d.sc_w      = 1'b1;
                        F5_AMOSWAP: d.amoswap_w = 1'b1;
                        F5_AMOADD:  d.amoadd_w  = 1'b1;
                        F5_AMOXOR:  d.amoxor_w  = 1'b1;
                        F5_AMOAND:  d.amoand_w  = 1'b1;
                        F5_AMOOR:   d.amoor_w   = 1'b1;
                        F5_AMOMIN:  d.amomin_w  = 1'b1;
                        F5_AMOMAX:  d.amomax_w  = 1'b1;
                        F5_AMOMINU: d.amominu_w = 1'b1;
                        F5_AMOMAXU: d.amomaxu_w = 1'b1;
                        default:    t_r         = 1'b0;
                    endcase
                    if (t_r) begin
                        d.aq       = instr_i[26];
                        d.rl       = instr_i[25];
                        d.is_load  = !d.sc_w;
                        d.is_store = !d.lr_w;
                    end
                end
            end
`endif
            default: ;
        endcase

        legal = t_r | t_i | t_s | t_b | t_u | t_j;

        if (legal) begin
            d.rd  = (t_r | t_i | t_u | t_j) ? instr_i[11:7]  : 5'd0;
            d.rs1 = (t_r | t_i | t_s | t_b) ? instr_i[19:15] : 5'd0;
            d.rs2 = (t_r | t_s | t_b)       ? instr_i[24:20] : 5'd0;
            if (t_i)      d.imm = imm_i(instr_i);
            else if (t_s) d.imm = imm_s(instr_i);
            else if (t_b) d.imm = imm_b(instr_i);
            else if (t_u) d.imm = imm_u(instr_i);
            else if (t_j) d.imm = imm_j(instr_i);
            else          d.imm = 32'd0;
            d.writes_to_reg = (t_r | t_i | t_u | t_j) &
                              !(d.fence | d.fence_i | d.ecall | d.ebreak);
        end

        d.illegal = !legal;
        d.pc      = pc_i;
        dec_o     = d;
    end

endmodule

// File: rtl/decode_stage.sv
// Buffered decode stage: decodes fetched words into a DEPTH-entry circular queue
// with valid/ready on both sides and a single-cycle flush. Optional RV32A decode
// is enabled with DECODE_RV32A_EN (see decode_comb).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output instructions              out_instr,
    output logic                     out_illegal,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    instructions dec;
    instructions slot_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    decode_comb u_decode_comb (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .dec_o   (dec)
    );

    // no pass-through when full: ready depends only on registered occupancy
    assign in_ready  = rstn && (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_instr   = out_valid ? slot_q[rptr_q] : '0;
    assign out_illegal = out_instr.illegal;
    assign rs1         = out_instr.rs1;
    assign rs2         = out_instr.rs2;
    assign count       = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // slot contents need no reset: an entry is only visible once counted
    always_ff @(posedge clk) begin
        if (push) slot_q[wptr_q] <= dec;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-decoded reference entries are queued on
// accepted pushes and compared against the head on each pop.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_pc, in_instr;
    instructions out_instr;
    logic [4:0]  rs1, rs2;
    logic [1:0]  count;

    always #5 clk = ~clk;

    decode_stage #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_illegal (out_illegal),
        .rs1         (rs1),
        .rs2         (rs2),
        .count       (count)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic        illegal;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        wr, ld, st, cj;
        int          flag;
    } exp_t;

    localparam int NVEC = 14;
    exp_t vec [NVEC];
    exp_t sbq [$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mcount   = 0;
    logic accepted;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] w, input logic ill, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                                input logic wr, input logic ld, input logic st, input logic cj,
                                input int fl);
        exp_t e;
        e.word = w; e.pc = 32'd0; e.illegal = ill; e.rd = d; e.rs1 = s1; e.rs2 = s2;
        e.imm = im; e.wr = wr; e.ld = ld; e.st = st; e.cj = cj; e.flag = fl;
        return e;
    endfunction

    function automatic logic get_flag(input instructions d, input int id);
        case (id)
            1:       return d.addi;
            2:       return d.add;
            3:       return d.sub;
            4:       return d.lw;
            5:       return d.sw;
            6:       return d.beq;
            7:       return d.lui;
            8:       return d.jal;
            9:       return d.mul;
            10:      return d.srai;
            11:      return d.amoadd_w;
            12:      return d.ecall;
            default: return 1'b0;
        endcase
    endfunction

    // one cycle: inputs already driven just after a falling edge
    task automatic step();
        exp_t        h;
        instructions tmp;
        #1;
        check_val("in_ready", 32'(in_ready), 32'(rstn && (mcount != DEPTH)));
        check_val("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
        check_val("count", 32'(count), 32'(mcount));
        if (sbq.size() != 0) begin
            h = sbq[0];
            check_val("rs1_port", 32'(rs1), 32'(h.rs1));
            check_val("rs2_port", 32'(rs2), 32'(h.rs2));
        end else begin
            check_val("rs1_empty", 32'(rs1), 32'd0);
            check_val("rs2_empty", 32'(rs2), 32'd0);
            check_val("instr_empty", 32'(out_instr == '0), 32'd1);
        end
        accepted = rstn && (mcount != DEPTH) && in_valid && !flush;
        if (!rstn || flush) begin
            sbq.delete();
        end else begin
            if (out_ready && sbq.size() != 0) begin
                h = sbq.pop_front();
                check_val("pc", out_instr.pc, h.pc);
                check_val("illegal", 32'(out_instr.illegal), 32'(h.illegal));
                check_val("out_illegal", 32'(out_illegal), 32'(h.illegal));
                check_val("rd", 32'(out_instr.rd), 32'(h.rd));
                check_val("rs1", 32'(out_instr.rs1), 32'(h.rs1));
                check_val("rs2", 32'(out_instr.rs2), 32'(h.rs2));
                check_val("imm", out_instr.imm, h.imm);
                check_val("writes_to_reg", 32'(out_instr.writes_to_reg), 32'(h.wr));
                check_val("is_load", 32'(out_instr.is_load), 32'(h.ld));
                check_val("is_store", 32'(out_instr.is_store), 32'(h.st));
                check_val("is_cond_jump", 32'(out_instr.is_conditional_jump), 32'(h.cj));
                if (h.flag == 0) begin
                    tmp = out_instr;
                    tmp.pc = '0;
                    tmp.illegal = 1'b0;
                    check_val("illegal_zero", 32'(tmp == '0), 32'd1);
                end else begin
                    check_val("op_flag", 32'(get_flag(out_instr, h.flag)), 32'd1);
                end
            end
            if (accepted) begin
                h = cur;
                h.pc = in_pc;
                sbq.push_back(h);
            end
        end
        mcount = sbq.size();
        @(negedge clk);
    endtask

    task automatic drive(input int idx, input logic [31:0] pc, input logic v,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = vec[idx].word;
        in_pc     = pc;
        cur       = vec[idx];
        out_ready = ordy;
        flush     = fl;
        step();
    endtask

    task automatic push_hold(input int idx, input logic [31:0] pc, input logic ordy);
        for (int k = 0; k < 20; k++) begin
            drive(idx, pc, 1'b1, ordy, 1'b0);
            if (accepted) break;
        end
        if (!accepted) check_val("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int k = 0; k < n; k++) drive(0, 32'd0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        vec[0]  = mk(32'hFFF10093, 0, 5'd1,  5'd2,  5'd0,  32'hFFFFFFFF, 1, 0, 0, 0, 1);  // addi x1,x2,-1
        vec[1]  = mk(32'h002081B3, 0, 5'd3,  5'd1,  5'd2,  32'h0,        1, 0, 0, 0, 2);  // add x3,x1,x2
        vec[2]  = mk(32'h407302B3, 0, 5'd5,  5'd6,  5'd7,  32'h0,        1, 0, 0, 0, 3);  // sub x5,x6,x7
        vec[3]  = mk(32'h0085A503, 0, 5'd10, 5'd11, 5'd0,  32'h8,        1, 1, 0, 0, 4);  // lw x10,8(x11)
        vec[4]  = mk(32'hFEC6AE23, 0, 5'd0,  5'd13, 5'd12, 32'hFFFFFFFC, 0, 0, 1, 0, 5);  // sw x12,-4(x13)
        vec[5]  = mk(32'hFE208CE3, 0, 5'd0,  5'd1,  5'd2,  32'hFFFFFFF8, 0, 0, 0, 1, 6);  // beq x1,x2,-8
        vec[6]  = mk(32'h123453B7, 0, 5'd7,  5'd0,  5'd0,  32'h12345000, 1, 0, 0, 0, 7);  // lui x7,0x12345
        vec[7]  = mk(32'h010000EF, 0, 5'd1,  5'd0,  5'd0,  32'h10,       1, 0, 0, 0, 8);  // jal x1,16
        vec[8]  = mk(32'h02628233, 0, 5'd4,  5'd5,  5'd6,  32'h0,        1, 0, 0, 0, 9);  // mul x4,x5,x6
        vec[9]  = mk(32'h4034D413, 0, 5'd8,  5'd9,  5'd0,  32'h403,      1, 0, 0, 0, 10); // srai x8,x9,3
        vec[10] = mk(32'h00000000, 1, 5'd0,  5'd0,  5'd0,  32'h0,        0, 0, 0, 0, 0);
        vec[11] = mk(32'h802081B3, 1, 5'd0,  5'd0,  5'd0,  32'h0,        0, 0, 0, 0, 0);  // bad funct7
`ifdef DECODE_RV32A_EN
        vec[12] = mk(32'h0020A1AF, 0, 5'd3,  5'd1,  5'd2,  32'h0,        1, 1, 1, 0, 11); // amoadd.w
`else
        vec[12] = mk(32'h0020A1AF, 1, 5'd0,  5'd0,  5'd0,  32'h0,        0, 0, 0, 0, 0);
`endif
        vec[13] = mk(32'h00000073, 0, 5'd0,  5'd0,  5'd0,  32'h0,        0, 0, 0, 0, 12); // ecall

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; cur = vec[0];
        @(negedge clk);
        idle(2, 1'b0);
        rstn = 1'b1;
        idle(1, 1'b0);

        // single word: visible one cycle later
        drive(0, 32'h100, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // full-rate stream of every vector
        for (int i = 0; i < NVEC; i++) push_hold(i, 32'h200 + 32'(4 * i), 1'b1);
        idle(3, 1'b1);

        // fill, stall, then drain; the third word waits for a freed slot
        drive(1, 32'h300, 1'b1, 1'b0, 1'b0);
        drive(2, 32'h304, 1'b1, 1'b0, 1'b0);
        drive(3, 32'h308, 1'b1, 1'b0, 1'b0);
        drive(3, 32'h308, 1'b1, 1'b1, 1'b0);
        drive(3, 32'h308, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // simultaneous push and pop at count 1
        drive(4, 32'h400, 1'b1, 1'b0, 1'b0);
        drive(5, 32'h404, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // flush with a full queue and a pending push
        drive(6, 32'h500, 1'b1, 1'b0, 1'b0);
        drive(7, 32'h504, 1'b1, 1'b0, 1'b0);
        drive(8, 32'h508, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // reset mid-operation
        drive(9, 32'h600, 1'b1, 1'b0, 1'b0);
        drive(10, 32'h604, 1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        idle(1, 1'b0);
        rstn = 1'b1;
        idle(2, 1'b1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            drive(int'($urandom_range(0, NVEC - 1)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0));
        end
        idle(4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
